peripheral_msi_slave_port_ahb3: RTL and testbench

//  Per-AHB-slave arbiter/mux; one instance per slave, downstream of all MSI master ports.

---
 rtl/peripheral_msi_slave_port_ahb3_if.sv | 30 +++
 rtl/peripheral_msi_slave_port_ahb3.sv | 123 ++++++++++++
 tb/tb_peripheral_msi_slave_port_ahb3.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_msi_slave_port_ahb3_if.sv
// AHB-Lite link between one per-slave arbiter and its downstream slave.
// The arbiter drives the address/data phase; the slave answers with data, ready and response.
interface peripheral_msi_slave_port_ahb3_if #(
    parameter int PLEN = 64,
    parameter int XLEN = 64
);
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HREADYOUT;
    logic            HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/peripheral_msi_slave_port_ahb3.sv
// Per-slave arbiter/mux: picks one of MASTERS master ports by priority with round-robin tie-break,
// muxes its address and data phases onto the slave, and broadcasts the slave response back.
module peripheral_msi_slave_port_ahb3 #(
    parameter int PLEN    = 64,
    parameter int XLEN    = 64,
    parameter int MASTERS = 5
) (
    input  logic                          HRESETn,
    input  logic                          HCLK,
    input  logic [MASTERS-1:0][2:0]       mstpriority,
    input  logic [MASTERS-1:0]            mstHSEL,
    input  logic [MASTERS-1:0][PLEN-1:0]  mstHADDR,
    input  logic [MASTERS-1:0][XLEN-1:0]  mstHWDATA,
    input  logic [MASTERS-1:0]            mstHWRITE,
    input  logic [MASTERS-1:0][2:0]       mstHSIZE,
    input  logic [MASTERS-1:0][2:0]       mstHBURST,
    input  logic [MASTERS-1:0][3:0]       mstHPROT,
    input  logic [MASTERS-1:0][1:0]       mstHTRANS,
    input  logic [MASTERS-1:0]            mstHMASTLOCK,
    input  logic [MASTERS-1:0]            mstHREADY,
    input  logic [MASTERS-1:0]            mst_can_switch,
    output logic [MASTERS-1:0]            master_granted,
    output logic [XLEN-1:0]               mstHRDATA,
    output logic                          mstHREADYOUT,
    output logic                          mstHRESP,
    peripheral_msi_slave_port_ahb3_if.master slv
);
    localparam int         IW          = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic [MASTERS-1:0] grant_q, grant_d;
    logic [MASTERS-1:0] data_owner_q, data_owner_d;
    logic [IW-1:0]      last_owner_q, last_owner_d;

    logic [IW-1:0] owner, data_idx, winner, cand;
    logic          owner_valid, data_valid, found, lock_hold, rearb, addr_sel;
    logic [2:0]    max_prio;
    int            idx;

    always_comb begin
        owner    = '0;
        data_idx = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (grant_q[i])      owner    = IW'(i);
            if (data_owner_q[i]) data_idx = IW'(i);
        end
    end

    assign owner_valid = |grant_q;
    assign data_valid  = |data_owner_q;

    // Highest requesting priority, then the first requester at that level after last_owner.
    always_comb begin
        max_prio = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (mstHSEL[i] && (mstpriority[i] > max_prio)) max_prio = mstpriority[i];
        end
        found  = 1'b0;
        winner = last_owner_q;
        idx    = 0;
        cand   = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            idx = int'(last_owner_q) + k;
            if (idx >= MASTERS) idx = idx - MASTERS;
            cand = IW'(idx);
            if (!found && mstHSEL[cand] && (mstpriority[cand] == max_prio)) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign addr_sel  = owner_valid & mstHSEL[owner];
    assign lock_hold = addr_sel & mstHMASTLOCK[owner];
    assign rearb     = slv.HREADYOUT & (~owner_valid | mst_can_switch[owner]) & ~lock_hold;

    always_comb begin
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        data_owner_d = data_owner_q;
        if (rearb) begin
            grant_d = '0;
            if (found) begin
                grant_d[winner] = 1'b1;
                last_owner_d    = winner;
            end
        end
        // The data phase follows the address phase the slave just accepted, independent of any regrant.
        if (slv.HREADYOUT) begin
            data_owner_d = (addr_sel && (mstHTRANS[owner] != HTRANS_IDLE)) ? grant_q : '0;
        end
    end

    // NOTE: every piece of arbitration state is cleared by the async reset so a mid-transfer reset leaves nothing stale.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q      <= '0;
            data_owner_q <= '0;
            last_owner_q <= IW'(MASTERS - 1);
        end else begin
            grant_q      <= grant_d;
            data_owner_q <= data_owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign master_granted = grant_q;

    assign slv.HSEL      = addr_sel;
    assign slv.HADDR     = owner_valid ? mstHADDR[owner]     : '0;
    assign slv.HWRITE    = owner_valid ? mstHWRITE[owner]    : 1'b0;
    assign slv.HSIZE     = owner_valid ? mstHSIZE[owner]     : '0;
    assign slv.HBURST    = owner_valid ? mstHBURST[owner]    : '0;
    assign slv.HPROT     = owner_valid ? mstHPROT[owner]     : '0;
    assign slv.HMASTLOCK = owner_valid ? mstHMASTLOCK[owner] : 1'b0;
    assign slv.HTRANS    = addr_sel    ? mstHTRANS[owner]    : HTRANS_IDLE;
    assign slv.HREADY    = owner_valid ? mstHREADY[owner]    : 1'b1;
    assign slv.HWDATA    = data_valid  ? mstHWDATA[data_idx] : '0;

    assign mstHRDATA    = slv.HRDATA;
    assign mstHREADYOUT = slv.HREADYOUT;
    assign mstHRESP     = slv.HRESP;
endmodule

// File: tb/tb_peripheral_msi_slave_port_ahb3.sv
// Directed bench for the per-slave arbiter: reset, single write, priority, round-robin,
// locked burst, slave wait states and asynchronous reset mid-transfer.
module tb_peripheral_msi_slave_port_ahb3;
    localparam int         PLEN    = 64;
    localparam int         XLEN    = 64;
    localparam int         MASTERS = 5;
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] NONSEQ  = 2'b10;
    localparam logic [1:0] SEQ     = 2'b11;

    logic clk = 1'b0;
    logic rst_n;

    logic [MASTERS-1:0][2:0]      prio;
    logic [MASTERS-1:0]           hsel, hwrite, lock, hready, cansw;
    logic [MASTERS-1:0][PLEN-1:0] haddr;
    logic [MASTERS-1:0][XLEN-1:0] hwdata;
    logic [MASTERS-1:0][2:0]      hsize, hburst;
    logic [MASTERS-1:0][3:0]      hprot;
    logic [MASTERS-1:0][1:0]      htrans;

    logic [MASTERS-1:0] granted;
    logic [XLEN-1:0]    rdata;
    logic               readyout, resp;

    int n_checks;
    int n_bad;

    peripheral_msi_slave_port_ahb3_if #(.PLEN(PLEN), .XLEN(XLEN)) bus ();

    peripheral_msi_slave_port_ahb3 #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(MASTERS)) dut (
        .HRESETn        (rst_n),
        .HCLK           (clk),
        .mstpriority    (prio),
        .mstHSEL        (hsel),
        .mstHADDR       (haddr),
        .mstHWDATA      (hwdata),
        .mstHWRITE      (hwrite),
        .mstHSIZE       (hsize),
        .mstHBURST      (hburst),
        .mstHPROT       (hprot),
        .mstHTRANS      (htrans),
        .mstHMASTLOCK   (lock),
        .mstHREADY      (hready),
        .mst_can_switch (cansw),
        .master_granted (granted),
        .mstHRDATA      (rdata),
        .mstHREADYOUT   (readyout),
        .mstHRESP       (resp),
        .slv            (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        prio   = '0;
        hsel   = '0;
        hwrite = '0;
        lock   = '0;
        hready = '1;
        cansw  = '1;
        haddr  = '0;
        hwdata = '0;
        hsize  = '0;
        hburst = '0;
        hprot  = '0;
        htrans = '0;
    endtask

    task automatic req(input int m, input logic [2:0] p, input logic [PLEN-1:0] a,
                       input logic w, input logic [XLEN-1:0] d);
        prio[m]   = p;
        hsel[m]   = 1'b1;
        htrans[m] = NONSEQ;
        haddr[m]  = a;
        hwrite[m] = w;
        hwdata[m] = d;
        hsize[m]  = 3'd2;
    endtask

    initial begin
        n_checks      = 0;
        n_bad         = 0;
        idle_all();
        bus.HREADYOUT = 1'b0;
        bus.HRDATA    = '0;
        bus.HRESP     = 1'b0;
        rst_n         = 1'b0;

        // Reset: a pending request and a clock edge must not produce a grant.
        req(2, 3'd1, 64'h1000, 1'b1, 64'hAA);
        #12;
        check("rst_grant",       64'(granted),       64'h0);
        check("rst_hsel",        64'(bus.HSEL),      64'h0);
        check("rst_htrans",      64'(bus.HTRANS),    64'(IDLE));
        check("rst_hready",      64'(bus.HREADY),    64'h1);
        check("rst_hreadyout_0", 64'(readyout),      64'h0);
        bus.HREADYOUT = 1'b1;
        #1;
        check("rst_hreadyout_1", 64'(readyout),      64'h1);
        idle_all();
        rst_n = 1'b1;
        step();

        // Single write from m2.
        req(2, 3'd1, 64'h1000, 1'b1, 64'hAA);
        #1;
        check("single_pre_grant", 64'(granted), 64'h0);
        step();
        check("single_grant",  64'(granted),    64'b00100);
        check("single_hsel",   64'(bus.HSEL),   64'h1);
        check("single_haddr",  bus.HADDR,       64'h1000);
        check("single_htrans", 64'(bus.HTRANS), 64'(NONSEQ));
        check("single_hwrite", 64'(bus.HWRITE), 64'h1);
        check("single_hwdata_addr_phase", bus.HWDATA, 64'h0);
        step();
        hsel[2]   = 1'b0;
        htrans[2] = IDLE;
        #1;
        check("single_hwdata",      bus.HWDATA,      64'hAA);
        check("single_grant_data",  64'(granted),    64'b00100);
        check("single_htrans_idle", 64'(bus.HTRANS), 64'(IDLE));
        step();
        check("single_release", 64'(granted), 64'h0);
        check("single_hwdata_0", bus.HWDATA, 64'h0);

        // Priority: m4 (5) beats m1 (3); m1 follows once m4 may switch.
        idle_all();
        req(1, 3'd3, 64'h100, 1'b1, 64'h11);
        req(4, 3'd5, 64'h400, 1'b0, 64'h0);
        cansw[4] = 1'b0;
        step();
        check("prio_grant_m4", 64'(granted), 64'b10000);
        check("prio_haddr_m4", bus.HADDR,    64'h400);
        step();
        check("prio_hold_m4",  64'(granted), 64'b10000);
        cansw[4]  = 1'b1;
        hsel[4]   = 1'b0;
        htrans[4] = IDLE;
        cansw[1]  = 1'b0;
        step();
        check("prio_grant_m1", 64'(granted), 64'b00010);
        check("prio_haddr_m1", bus.HADDR,    64'h100);
        step();
        check("prio_m1_data",  bus.HWDATA,   64'h11);

        // Asynchronous reset mid-transfer clears grant and data owner without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant",  64'(granted),    64'h0);
        check("arst_hwdata", bus.HWDATA,      64'h0);
        check("arst_hsel",   64'(bus.HSEL),   64'h0);
        check("arst_hready", 64'(bus.HREADY), 64'h1);
        idle_all();
        #1;
        rst_n = 1'b1;

        // Round-robin among equal priorities, starting after last_owner = 4.
        req(0, 3'd2, 64'h00, 1'b0, 64'h0);
        req(1, 3'd2, 64'h10, 1'b0, 64'h0);
        req(3, 3'd2, 64'h30, 1'b0, 64'h0);
        step();
        check("rr_1_m0", 64'(granted), 64'b00001);
        step();
        check("rr_2_m1", 64'(granted), 64'b00010);
        step();
        check("rr_3_m3", 64'(granted), 64'b01000);
        check("rr_3_haddr", bus.HADDR, 64'h30);
        step();
        check("rr_4_m0", 64'(granted), 64'b00001);

        // Locked INCR4 burst from m0 holds off a higher-priority m2.
        idle_all();
        step();
        check("lock_idle", 64'(granted), 64'h0);
        req(0, 3'd2, 64'h2000, 1'b1, 64'h0);
        hburst[0] = 3'd3;
        lock[0]   = 1'b1;
        step();
        req(2, 3'd7, 64'h5000, 1'b0, 64'h0);
        #1;
        check("lock_grant_m0", 64'(granted),       64'b00001);
        check("lock_beat0",    bus.HADDR,          64'h2000);
        check("lock_mastlock", 64'(bus.HMASTLOCK), 64'h1);
        check("lock_hburst",   64'(bus.HBURST),    64'h3);
        for (int b = 1; b < 4; b++) begin
            step();
            haddr[0]  = 64'h2000 + 64'(4 * b);
            htrans[0] = SEQ;
            #1;
            check($sformatf("lock_grant_beat%0d", b), 64'(granted), 64'b00001);
            check($sformatf("lock_haddr_beat%0d", b), bus.HADDR, 64'h2000 + 64'(4 * b));
        end
        step();
        hsel[0]   = 1'b0;
        lock[0]   = 1'b0;
        htrans[0] = IDLE;
        #1;
        check("lock_last_data", 64'(granted), 64'b00001);
        check("lock_idle_addr", 64'(bus.HTRANS), 64'(IDLE));
        step();
        check("lock_grant_m2", 64'(granted), 64'b00100);
        check("lock_haddr_m2", bus.HADDR,    64'h5000);

        // Slave wait states during m1 data phase; m3 waits meanwhile.
        idle_all();
        step();
        req(1, 3'd2, 64'h3000, 1'b1, 64'h55);
        step();
        check("wait_grant_m1", 64'(granted), 64'b00010);
        step();
        hsel[1]       = 1'b0;
        htrans[1]     = IDLE;
        hready[1]     = 1'b0;
        req(3, 3'd1, 64'h7000, 1'b0, 64'h0);
        bus.HREADYOUT = 1'b0;
        bus.HRDATA    = 64'hDEAD;
        bus.HRESP     = 1'b1;
        #1;
        check("wait_readyout_0", 64'(readyout),    64'h0);
        check("wait_grant_0",    64'(granted),     64'b00010);
        check("wait_hwdata_0",   bus.HWDATA,       64'h55);
        check("wait_hready_mux", 64'(bus.HREADY),  64'h0);
        check("wait_hrdata",     rdata,            64'hDEAD);
        check("wait_hresp",      64'(resp),        64'h1);
        for (int c = 1; c < 3; c++) begin
            step();
            check($sformatf("wait_grant_%0d", c),    64'(granted),  64'b00010);
            check($sformatf("wait_hwdata_%0d", c),   bus.HWDATA,    64'h55);
            check($sformatf("wait_readyout_%0d", c), 64'(readyout), 64'h0);
        end
        bus.HREADYOUT = 1'b1;
        #1;
        check("wait_readyout_1", 64'(readyout), 64'h1);
        step();
        check("wait_grant_m3",   64'(granted),  64'b01000);
        check("wait_hwdata_end", bus.HWDATA,    64'h0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
